// File: rtl/carry_skip_adder_pipe_pkg.sv
// Shared definitions for the pipelined carry-skip adder/subtractor.
// Holds the default geometry and the latency helper that the top level uses
// to size its stage chain.
package carry_skip_adder_pipe_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_BLK   = 4;
   localparam int DEF_SEG   = 2;

   // Number of pipeline stages: each stage resolves BLK*SEG result bits.
   function automatic int csa_lat(input int width, input int blk, input int seg);
      return width / (blk * seg);
   endfunction

endpackage

// File: rtl/carry_skip_adder_pipe_csa_skip_block.sv
// csa_skip_block: BLK-bit ripple-carry block with a skip multiplexer.
// When every bit position propagates, the incoming carry is steered straight
// to cout, so the critical path does not have to ripple through this block.
// Ports:
//   a, b  in  BLK  operand bits (b already conditioned for subtract)
//   cin   in  1    carry into the block
//   s     out BLK  block sum
//   cout  out 1    carry out (skip path when p=1)
//   p     out 1    block propagate, AND of a_i ^ b_i
module csa_skip_block
   import carry_skip_adder_pipe_pkg::*;
#(
   parameter int BLK = DEF_BLK
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           cin,
   output logic [BLK-1:0] s,
   output logic           cout,
   output logic           p
);

   logic [BLK:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < BLK; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign p    = &(a ^ b);
   assign cout = p ? cin : c[BLK];

endmodule

// File: rtl/carry_skip_adder_pipe.sv
// carry_skip_adder_pipe: pipelined carry-skip adder/subtractor with a
// valid/ready handshake on both sides and a single global advance.
// Stage k resolves bits [k*BLK*SEG +: BLK*SEG] from the carry registered by
// stage k-1; not-yet-summed operand bits ride along in shrinking registers and
// finished low sum bits in growing ones, so the full word emerges aligned.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready = pipeline advance)
//   a, b, cin, sub      operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready result handshake
//   s, cout, ovf        sum, MSB carry-out (1 = no borrow), signed overflow
module carry_skip_adder_pipe
   import carry_skip_adder_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLK   = DEF_BLK,
   parameter int SEG   = DEF_SEG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int STG_W = BLK * SEG;
   localparam int LAT   = csa_lat(WIDTH, BLK, SEG);
   localparam int NBLK  = WIDTH / BLK;

   if ((WIDTH % STG_W != 0) || (NBLK * BLK != WIDTH)) begin : g_bad_geometry
      $error("carry_skip_adder_pipe: WIDTH must be a multiple of BLK*SEG");
   end

   logic             out_valid_q;
   logic [WIDTH-1:0] s_q;
   logic             cout_q;
   logic             ovf_q;
   logic             adv;

   // No skid buffer: a held result stalls every stage and the input at once.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < LAT; k++) begin : g_stg
      localparam int LO = k * STG_W;     // result bits finished before stage k
      localparam int HW = WIDTH - LO;    // operand bits still to be summed

      logic [HW-1:0]          a_in;
      logic [HW-1:0]          bb_in;
      logic                   c_in;
      logic                   vld_in;
      logic [STG_W-1:0]       sum_slc;
      logic [SEG:0]           c_blk;
      logic [SEG-1:0]         p_blk;
      logic                   c_d;
      logic [LO+STG_W-1:0]    s_d;

      // ---- stage k inputs: primary operands or previous stage registers ----
      if (k == 0) begin : g_in
         assign a_in   = a;
         assign bb_in  = b ^ {WIDTH{sub}};
         assign c_in   = sub | cin;
         assign vld_in = in_valid;
         assign s_d    = sum_slc;
      end else begin : g_in
         assign a_in   = g_stg[k-1].g_reg.a_q;
         assign bb_in  = g_stg[k-1].g_reg.bb_q;
         assign c_in   = g_stg[k-1].g_reg.c_q;
         assign vld_in = g_stg[k-1].g_reg.vld_q;
         assign s_d    = {sum_slc, g_stg[k-1].g_reg.s_q};
      end

      assign c_blk[0] = c_in;
      for (genvar j = 0; j < SEG; j++) begin : g_blk
         csa_skip_block #(.BLK(BLK)) u_blk (
            .a    (a_in[j*BLK +: BLK]),
            .b    (bb_in[j*BLK +: BLK]),
            .cin  (c_blk[j]),
            .s    (sum_slc[j*BLK +: BLK]),
            .cout (c_blk[j+1]),
            .p    (p_blk[j])
         );
      end

      // Second skip level: if all SEG blocks propagate, the stage carry is
      // the incoming carry without waiting on the block chain.
      assign c_d = (&p_blk) ? c_in : c_blk[SEG];

      if (k < LAT - 1) begin : g_reg
         logic [HW-STG_W-1:0]   a_q;
         logic [HW-STG_W-1:0]   bb_q;
         logic [LO+STG_W-1:0]   s_q;
         logic                  c_q;
         logic                  vld_q;

         // ---- stage k -> k+1 register boundary ----
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= 1'b0;
            end else if (adv) begin
               vld_q <= vld_in;
            end
         end

         always_ff @(posedge clk) begin
            if (adv) begin
               a_q  <= a_in[HW-1:STG_W];
               bb_q <= bb_in[HW-1:STG_W];
               s_q  <= s_d;
               c_q  <= c_d;
            end
         end
      end else begin : g_out
         logic c_msb;

         // Carry into the MSB recovered from its sum bit: s = a ^ b' ^ c.
         assign c_msb = s_d[WIDTH-1] ^ a_in[HW-1] ^ bb_in[HW-1];

         // ---- final stage -> output register boundary ----
         always_ff @(posedge clk) begin
            if (rst) begin
               out_valid_q <= 1'b0;
               s_q         <= '0;
               cout_q      <= 1'b0;
               ovf_q       <= 1'b0;
            end else if (adv) begin
               out_valid_q <= vld_in;
               // Bubbles leave the last delivered result on the outputs.
               if (vld_in) begin
                  s_q    <= s_d;
                  cout_q <= c_d;
                  ovf_q  <= c_msb ^ c_d;
               end
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
module tb_carry_skip_adder_pipe;

   localparam int W   = 32;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  s;
   logic          cout;
   logic          ovf;

   int total = 0;
   int bad   = 0;

   carry_skip_adder_pipe #(.WIDTH(W), .BLK(4), .SEG(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated operation: checks latency in cycles and the result fields.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts,
                         input logic [W-1:0] es, input logic ec, input logic eo);
      int n;
      @(negedge clk);
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"},  n,    LAT);
      chk({tag, "_s"},    s,    es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"},  ovf,  eo);
   endtask

   // Streams n random additions; out_ready is low for cycles st_lo..st_hi.
   task automatic stream(input string tag, input int n, input int st_lo, input int st_hi);
      logic [W-1:0] av [32];
      logic [W-1:0] bv [32];
      logic         cv [32];
      logic [W+1:0] eq [$];
      logic [W:0]   sum;
      int sent  = 0;
      int recv  = 0;
      int first = -1;
      int last  = -1;
      for (int i = 0; i < n; i++) begin
         av[i] = $urandom;
         bv[i] = $urandom;
         cv[i] = 1'($urandom_range(0, 1));
      end
      for (int cyc = 0; cyc < n + 30 && recv < n; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= st_lo && cyc <= st_hi);
         #1;
         if (out_valid) begin
            if (eq.size() == 0) begin
               chk({tag, "_extra"}, out_valid, 1'b0);
            end else begin
               chk({tag, "_s"},    s,    eq[0][W-1:0]);
               chk({tag, "_cout"}, cout, eq[0][W]);
               chk({tag, "_ovf"},  ovf,  eq[0][W+1]);
               if (out_ready) begin
                  void'(eq.pop_front());
                  recv++;
                  if (first < 0) first = cyc;
                  last = cyc;
               end else begin
                  chk({tag, "_stall_rdy"}, in_ready, 1'b0);
               end
            end
         end
         in_valid = (sent < n);
         if (sent < n) begin
            a = av[sent]; b = bv[sent]; cin = cv[sent]; sub = 1'b0;
            if (in_ready) begin
               sum = {1'b0, av[sent]} + {1'b0, bv[sent]} + {{W{1'b0}}, cv[sent]};
               eq.push_back({(av[sent][W-1] == bv[sent][W-1]) && (sum[W-1] != av[sent][W-1]), sum});
               sent++;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk({tag, "_count"}, recv, n);
      if (st_lo < 0) chk({tag, "_span"}, last - first, n - 1);
      else           chk({tag, "_span"}, last - first, n - 1 + (st_hi - st_lo + 1));
      @(negedge clk);
      chk({tag, "_drain"}, out_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_s",         s,         '0);
      chk("rst_cout",      cout,      1'b0);
      chk("rst_ovf",       ovf,       1'b0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready",  in_ready,  1'b1);

      run_op("add_small", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0);
      run_op("skip_all",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_op("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_op("sub_pos",   32'd10,        32'd3,         1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
      run_op("sub_neg",   32'd3,         32'd10,        1'b1, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0);
      run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

      stream("stream", 20, -1, -1);
      stream("bp", 6, 5, 7);

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 32'(i + 1); b = 32'h100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid",  out_valid, 1'b0);
      chk("mid_rst_ready",  in_ready,  1'b1);
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         chk("mid_rst_quiet", out_valid, 1'b0);
      end
      run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
